// File: rtl/reset_sequencer.sv
// Staged reset controller: holds the SoC in reset, waits for PLL lock, then
// releases flash, memory/peripheral and CPU domains in order. Restarts on
// lock loss, software request, or (optionally) watchdog expiry.
// Optional watchdog is built only when RESET_SEQ_WDT_EN is defined.
module reset_sequencer #(
  parameter int unsigned HOLD_CLOCKS  = 800,
  parameter int unsigned STAGE_GAP    = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned WDT_CLOCKS   = 1000000
) (
  input  logic clock48,
  input  logic reseted,
  input  logic pll_locked,
  input  logic sw_reset_req,
  output logic sw_reset_ack,
  input  logic wdt_kick,
  output logic resetn_flash,
  output logic resetn_mem,
  output logic resetn_cpu,
  output logic busy,
  output logic lock_fail,
  output logic wdt_fired
);

  localparam logic [2:0] HOLD      = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] REL_FLASH = 3'd2;
  localparam logic [2:0] REL_MEM   = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;

  localparam logic [31:0] HOLD_LAST = HOLD_CLOCKS - 1;
  localparam logic [31:0] GAP_LAST  = STAGE_GAP - 1;
  localparam logic [31:0] LOCK_LAST = LOCK_TIMEOUT - 1;

  logic        lock_meta, lock_s;
  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ack_d, lock_fail_d, wdt_fired_d;
  logic        wdt_expire;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clock48 or posedge reseted) begin
    if (reseted) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

`ifdef RESET_SEQ_WDT_EN
  localparam logic [31:0] WDT_LAST = WDT_CLOCKS - 1;

  logic [31:0] wdt_cnt_q, wdt_cnt_d;

  // A kick in the expiry cycle still rescues the system
  assign wdt_expire = (state_q == RUN) && !wdt_kick && (wdt_cnt_q == WDT_LAST);

  // Watchdog counts only while staying in RUN; held at zero elsewhere
  always_comb begin
    wdt_cnt_d = '0;
    if ((state_q == RUN) && (state_d == RUN)) begin
      wdt_cnt_d = wdt_kick ? '0 : wdt_cnt_q + 32'd1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clock48 or posedge reseted) begin
    if (reseted) begin
      wdt_cnt_q <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
    end
  end
`else
  logic unused_wdt;

  assign wdt_expire = 1'b0;
  // Watchdog not built: kick input and period are intentionally unused
  assign unused_wdt = wdt_kick ^ (WDT_CLOCKS == 32'd0);
`endif

  // Next-state, sticky-flag and acknowledge decode
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    lock_fail_d = lock_fail;
    wdt_fired_d = wdt_fired;
    case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = REL_FLASH;
        end else if (cnt_q == LOCK_LAST) begin
          state_d     = HOLD;
          lock_fail_d = 1'b1;
        end
      end
      REL_FLASH: begin
        if (!lock_s) state_d = HOLD;
        else if (cnt_q == GAP_LAST) state_d = REL_MEM;
      end
      REL_MEM: begin
        if (!lock_s) state_d = HOLD;
        else if (cnt_q == GAP_LAST) state_d = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_d = HOLD;
        end else if (sw_reset_req) begin
          state_d = HOLD;
          ack_d   = 1'b1;
        end else if (wdt_expire) begin
          state_d     = HOLD;
          wdt_fired_d = 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
    // Counter restarts from zero on every state entry
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 32'd1;
  end

  // State, counter and outputs; outputs decoded from the next state
  always_ff @(posedge clock48 or posedge reseted) begin
    if (reseted) begin
      state_q      <= HOLD;
      cnt_q        <= '0;
      resetn_flash <= 1'b0;
      resetn_mem   <= 1'b0;
      resetn_cpu   <= 1'b0;
      busy         <= 1'b1;
      sw_reset_ack <= 1'b0;
      lock_fail    <= 1'b0;
      wdt_fired    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resetn_flash <= (state_d == REL_FLASH) || (state_d == REL_MEM) || (state_d == RUN);
      resetn_mem   <= (state_d == REL_MEM) || (state_d == RUN);
      resetn_cpu   <= (state_d == RUN);
      busy         <= (state_d != RUN);
      sw_reset_ack <= ack_d;
      lock_fail    <= lock_fail_d;
      wdt_fired    <= wdt_fired_d;
    end
  end

endmodule
